apb_req_arbiter: RTL and testbench
==================================

APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data width of the requester and master data buses.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, address width.
REQ-003 SHALL have parameter ERR_WIDTH, default 2, width of the fail code, formatted {timeout, slverr}.
REQ-004 SHALL have parameter TOUT_CYCLES, default 16, the timeout limit in PCLK cycles.
REQ-005 SHALL have the following ports, one per line as name, direction, width, meaning:
- PCLK  in  1  clock.
- PRESETn  in  1  reset, asynchronous, active-low.
- REQ_i  in  4  per-requester level request.
- RW_i  in  4  per-requester direction; 1 = write.
- ADDR_i  in  4*ADDR_WIDTH  per-requester address; requester n occupies slice n.
- WDATA_i  in  4*DATA_WIDTH  per-requester write data.
- GNT_o  out  4  one-hot grant, held from issue through completion.
- ACK_o  out  4  one-hot completion pulse.
- RDATA_o  out  DATA_WIDTH  captured read data.
- FAIL_o  out  ERR_WIDTH  captured fail code.
- TRANSFER_o  out  1  one-cycle launch pulse to the APB master.
- RW_o  out  1  granted direction.
- ADDR_o  out  ADDR_WIDTH  granted address.
- WDATA_o  out  DATA_WIDTH  granted write data.
- DONE_i  in  1  APB master completion pulse.
- FAIL_i  in  ERR_WIDTH  APB master fail code.
- RDATA_i  in  DATA_WIDTH  APB master read data.
- TOUT_o  out  1  timeout indication to the APB master.

Function
REQ-006 SHALL implement FSM states IDLE, ISSUE, WAIT and COMPLETE, and SHALL register all outputs.
REQ-007 In IDLE, when any REQ_i bit is 1, the arbiter SHALL select a winner round-robin and go to ISSUE; otherwise it SHALL stay in IDLE.
- Priority search SHALL start at last_grant+1, modulo 4.
- last_grant SHALL reset to 3, so requester 0 has first priority.
REQ-008 In ISSUE, the arbiter SHALL hold for exactly one cycle:
- TRANSFER_o=1;
- RW_o, ADDR_o and WDATA_o driven from the winner's slices;
- GNT_o set to the winner's one-hot bit.
REQ-009 The arbiter SHALL go from ISSUE to WAIT unconditionally.
REQ-010 In WAIT:
- TRANSFER_o SHALL be 0.
- GNT_o, RW_o, ADDR_o and WDATA_o SHALL hold their values.
- The state SHALL stay WAIT until DONE_i=1.
REQ-011 On a cycle in WAIT with DONE_i=1, the arbiter SHALL capture RDATA_i into RDATA_o and FAIL_i into FAIL_o, and go to COMPLETE.
REQ-012 In COMPLETE, the arbiter SHALL:
- drive ACK_o equal to GNT_o for exactly one cycle;
- update last_grant;
- go to IDLE.
REQ-013 On leaving COMPLETE, GNT_o SHALL clear to 0.
REQ-014 RDATA_o and FAIL_o SHALL hold their values until the next capture.
REQ-015 Each requester SHALL hold REQ_i and its slices stable until its ACK_o, and SHALL drop REQ_i by the cycle after ACK_o.
- A REQ_i still high in IDLE SHALL be treated as a new request.
REQ-016 DONE_i SHALL be ignored in IDLE, ISSUE and COMPLETE.
REQ-017 TRANSFER_o SHALL never be 1 in two consecutive cycles.
REQ-018 Latency SHALL be: REQ_i sampled in IDLE at edge t gives TRANSFER_o=1 in cycle t+1.
REQ-019 DONE_i at edge d SHALL give ACK_o=1 in cycle d+1.
REQ-020 Requests that arrive simultaneously SHALL be granted one at a time in round-robin order, each with its own full ISSUE-WAIT-COMPLETE sequence.
REQ-021 An unknown or illegal state SHALL go to IDLE.

Reset
REQ-022 While PRESETn=0, the arbiter SHALL asynchronously set:
- state to IDLE and last_grant to 3;
- GNT_o, ACK_o, TRANSFER_o, RW_o and TOUT_o to 0;
- ADDR_o, WDATA_o, RDATA_o and FAIL_o to 0;
- the timeout counter to 0.
REQ-023 A reset asserted mid-transaction SHALL abandon that transaction with no ACK_o.
- After release, the arbiter SHALL re-arbitrate from IDLE.

Configuration
REQ-024 Macro APB_REQ_ARB_TOUT_EN, when defined, SHALL add a timeout counter with the following behaviour:
- The counter SHALL clear in ISSUE.
- It SHALL increment each WAIT cycle, saturating at TOUT_CYCLES.
- TOUT_o SHALL be 1 while in WAIT with count==TOUT_CYCLES.
- TOUT_o SHALL clear on the cycle after DONE_i.
REQ-025 When APB_REQ_ARB_TOUT_EN is undefined, TOUT_o SHALL be tied to 0 and no counter SHALL be synthesized.

Verification
REQ-026 Single request: REQ_i=4'b0001, RW_i[0]=1, ADDR=0x10, WDATA=0xA5A5A5A5 -> TRANSFER_o pulse with ADDR_o=0x10 and WDATA_o=0xA5A5A5A5; DONE_i two cycles later -> ACK_o=4'b0001 next cycle, FAIL_o=0.
REQ-027 Read capture: requester 2 reads with RDATA_i=0xDEADBEEF at DONE_i -> RDATA_o=0xDEADBEEF, ACK_o=4'b0100.
REQ-028 Round-robin: REQ_i=4'b1111 held -> grant order 0,1,2,3,0, one TRANSFER_o per grant.
REQ-029 Timeout, with the macro defined and TOUT_CYCLES=4: DONE_i withheld -> TOUT_o=1 after 4 WAIT cycles; DONE_i with FAIL_i=2'b10 -> FAIL_o=2'b10, TOUT_o=0 on the following cycle.
REQ-030 Reset mid-WAIT: PRESETn pulsed low -> all outputs 0 and no ACK_o; REQ_i=4'b0010 after release -> GNT_o=4'b0010.
REQ-031 Spurious DONE_i in IDLE -> no state change and no ACK_o.

Source files
------------

// File: rtl/apb_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : apb_req_arbiter
//  Description : Four-requester round-robin arbiter in front of an APB master.
//                Each grant runs a full ISSUE -> WAIT -> COMPLETE sequence.
//                All outputs are registered.
//                Optional timeout counter enabled by `APB_REQ_ARB_TOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_req_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int ERR_WIDTH   = 2,
  parameter int TOUT_CYCLES = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic [3:0]              REQ_i,
  input  logic [3:0]              RW_i,
  input  logic [4*ADDR_WIDTH-1:0] ADDR_i,
  input  logic [4*DATA_WIDTH-1:0] WDATA_i,
  output logic [3:0]              GNT_o,
  output logic [3:0]              ACK_o,
  output logic [DATA_WIDTH-1:0]   RDATA_o,
  output logic [ERR_WIDTH-1:0]    FAIL_o,
  output logic                    TRANSFER_o,
  output logic                    RW_o,
  output logic [ADDR_WIDTH-1:0]   ADDR_o,
  output logic [DATA_WIDTH-1:0]   WDATA_o,
  input  logic                    DONE_i,
  input  logic [ERR_WIDTH-1:0]    FAIL_i,
  input  logic [DATA_WIDTH-1:0]   RDATA_i,
  output logic                    TOUT_o
);

  localparam logic [1:0] c_IDLE     = 2'd0;
  localparam logic [1:0] c_ISSUE    = 2'd1;
  localparam logic [1:0] c_WAIT     = 2'd2;
  localparam logic [1:0] c_COMPLETE = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [1:0]            last_q, last_d;
  logic [1:0]            cur_q, cur_d;
  logic [3:0]            gnt_q, gnt_d;
  logic [3:0]            ack_q, ack_d;
  logic                  transfer_q, transfer_d;
  logic                  rw_q, rw_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [ERR_WIDTH-1:0]  fail_q, fail_d;

  logic [1:0]            w_win;
  logic [1:0]            w_idx;
  logic                  w_win_vld;
  logic [ADDR_WIDTH-1:0] w_addr  [4];
  logic [DATA_WIDTH-1:0] w_wdata [4];

  // Unpack the flat per-requester buses into indexable slices.
  genvar g;
  for (g = 0; g < 4; g++) begin : g_slice
    assign w_addr[g]  = ADDR_i[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_wdata[g] = WDATA_i[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin search starting one past the last completed grant.
  always_comb begin
    w_win_vld = 1'b0;
    w_win     = 2'd0;
    w_idx     = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      w_idx = last_q + k[1:0];
      if (!w_win_vld && REQ_i[w_idx]) begin
        w_win_vld = 1'b1;
        w_win     = w_idx;
      end
    end
  end

  // Next-state and next-output logic; pulses default low, the rest hold.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    cur_d      = cur_q;
    gnt_d      = gnt_q;
    ack_d      = 4'b0000;
    transfer_d = 1'b0;
    rw_d       = rw_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    fail_d     = fail_q;
    case (state_q)
      c_IDLE: begin
        if (w_win_vld) begin
          state_d    = c_ISSUE;
          cur_d      = w_win;
          gnt_d      = 4'b0001 << w_win;
          transfer_d = 1'b1;
          rw_d       = RW_i[w_win];
          addr_d     = w_addr[w_win];
          wdata_d    = w_wdata[w_win];
        end
      end
      c_ISSUE: begin
        state_d = c_WAIT;
      end
      c_WAIT: begin
        if (DONE_i) begin
          state_d = c_COMPLETE;
          rdata_d = RDATA_i;
          fail_d  = FAIL_i;
          ack_d   = gnt_q;
        end
      end
      c_COMPLETE: begin
        state_d = c_IDLE;
        last_d  = cur_q;
        gnt_d   = 4'b0000;
      end
      default: begin
        state_d = c_IDLE;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q    <= c_IDLE;
      last_q     <= 2'd3;
      cur_q      <= 2'd0;
      gnt_q      <= 4'b0000;
      ack_q      <= 4'b0000;
      transfer_q <= 1'b0;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      fail_q     <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      cur_q      <= cur_d;
      gnt_q      <= gnt_d;
      ack_q      <= ack_d;
      transfer_q <= transfer_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      fail_q     <= fail_d;
    end
  end

  assign GNT_o      = gnt_q;
  assign ACK_o      = ack_q;
  assign TRANSFER_o = transfer_q;
  assign RW_o       = rw_q;
  assign ADDR_o     = addr_q;
  assign WDATA_o    = wdata_q;
  assign RDATA_o    = rdata_q;
  assign FAIL_o     = fail_q;

`ifdef APB_REQ_ARB_TOUT_EN
  localparam int              c_CW       = $clog2(TOUT_CYCLES + 1);
  localparam logic [c_CW-1:0] c_TOUT_MAX = c_CW'(TOUT_CYCLES);

  logic [c_CW-1:0] cnt_q, cnt_d;
  logic            tout_q, tout_d;

  // Count WAIT cycles, saturating; flag timeout only while still waiting.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == c_ISSUE) begin
      cnt_d = '0;
    end else if (state_q == c_WAIT && !DONE_i && cnt_q != c_TOUT_MAX) begin
      cnt_d = cnt_q + c_CW'(1);
    end
    tout_d = (state_d == c_WAIT) && (cnt_d == c_TOUT_MAX);
  end

  // Timeout counter and flag registers.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cnt_q  <= '0;
      tout_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tout_q <= tout_d;
    end
  end

  assign TOUT_o = tout_q;
`else
  assign TOUT_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_apb_req_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_apb_req_arbiter
//  Description : Self-checking bench for apb_req_arbiter with a transaction
//                level round-robin reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_req_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int EW = 2;
  localparam int TC = 4;

  logic          PCLK = 1'b0;
  logic          PRESETn;
  logic [3:0]    REQ_i, RW_i;
  logic [4*AW-1:0] ADDR_i;
  logic [4*DW-1:0] WDATA_i;
  logic [3:0]    GNT_o, ACK_o;
  logic [DW-1:0] RDATA_o, WDATA_o, RDATA_i;
  logic [EW-1:0] FAIL_o, FAIL_i;
  logic          TRANSFER_o, RW_o, DONE_i, TOUT_o;
  logic [AW-1:0] ADDR_o;

  int checks = 0;
  int errors = 0;
  int exp_last = 3;

  apb_req_arbiter #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .ERR_WIDTH  (EW),
    .TOUT_CYCLES(TC)
  ) dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .REQ_i     (REQ_i),
    .RW_i      (RW_i),
    .ADDR_i    (ADDR_i),
    .WDATA_i   (WDATA_i),
    .GNT_o     (GNT_o),
    .ACK_o     (ACK_o),
    .RDATA_o   (RDATA_o),
    .FAIL_o    (FAIL_o),
    .TRANSFER_o(TRANSFER_o),
    .RW_o      (RW_o),
    .ADDR_o    (ADDR_o),
    .WDATA_o   (WDATA_o),
    .DONE_i    (DONE_i),
    .FAIL_i    (FAIL_i),
    .RDATA_i   (RDATA_i),
    .TOUT_o    (TOUT_o)
  );

  always #5 PCLK = ~PCLK;

  // Reference rule: first requesting index after the previous winner, mod 4.
  function automatic int rr_pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++)
      if (r[(last + k) % 4]) return (last + k) % 4;
    return 0;
  endfunction

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // One full transaction for the currently pending requests.
  task automatic run_txn(input int dly, input logic [EW-1:0] fl,
                         input logic [DW-1:0] rd, input bit drop, output int w);
    logic [3:0] oh;
    w  = rr_pick(REQ_i, exp_last);
    oh = 4'b0001 << w;
    tick();
    checks++; if (TRANSFER_o !== 1'b1) begin errors++; $display("FAIL issue_transfer got %b exp 1", TRANSFER_o); end
    checks++; if (GNT_o !== oh) begin errors++; $display("FAIL issue_gnt got %b exp %b", GNT_o, oh); end
    checks++; if (ADDR_o !== ADDR_i[w*AW +: AW]) begin errors++; $display("FAIL issue_addr got %h exp %h", ADDR_o, ADDR_i[w*AW +: AW]); end
    checks++; if (WDATA_o !== WDATA_i[w*DW +: DW]) begin errors++; $display("FAIL issue_wdata got %h exp %h", WDATA_o, WDATA_i[w*DW +: DW]); end
    checks++; if (RW_o !== RW_i[w]) begin errors++; $display("FAIL issue_rw got %b exp %b", RW_o, RW_i[w]); end
    for (int i = 0; i < dly; i++) begin
      tick();
      checks++;
      if (TRANSFER_o !== 1'b0 || GNT_o !== oh || ACK_o !== 4'b0 || TOUT_o !== 1'b0) begin
        errors++;
        $display("FAIL wait_hold got tr=%b gnt=%b ack=%b tout=%b exp tr=0 gnt=%b ack=0 tout=0",
                 TRANSFER_o, GNT_o, ACK_o, TOUT_o, oh);
      end
    end
    DONE_i = 1'b1; FAIL_i = fl; RDATA_i = rd;
    tick();
    DONE_i = 1'b0; FAIL_i = ~fl; RDATA_i = ~rd;
    checks++; if (ACK_o !== oh || GNT_o !== oh) begin errors++; $display("FAIL complete_ack got ack=%b gnt=%b exp %b", ACK_o, GNT_o, oh); end
    checks++; if (RDATA_o !== rd) begin errors++; $display("FAIL rdata_capture got %h exp %h", RDATA_o, rd); end
    checks++; if (FAIL_o !== fl) begin errors++; $display("FAIL fail_capture got %b exp %b", FAIL_o, fl); end
    if (drop) REQ_i[w] = 1'b0;
    exp_last = w;
    tick();
    checks++;
    if (ACK_o !== 4'b0 || GNT_o !== 4'b0 || TRANSFER_o !== 1'b0 || RDATA_o !== rd || FAIL_o !== fl) begin
      errors++;
      $display("FAIL idle_after got ack=%b gnt=%b tr=%b rdata=%h fail=%b exp 0 0 0 %h %b",
               ACK_o, GNT_o, TRANSFER_o, RDATA_o, FAIL_o, rd, fl);
    end
  endtask

  task automatic test_reset();
    PRESETn = 1'b0;
    REQ_i = 4'b0; RW_i = 4'b0; ADDR_i = '0; WDATA_i = '0;
    DONE_i = 1'b0; FAIL_i = '0; RDATA_i = '0;
    tick(); tick();
    checks++;
    if (GNT_o !== 4'b0 || ACK_o !== 4'b0 || TRANSFER_o !== 1'b0 || RW_o !== 1'b0 || TOUT_o !== 1'b0 ||
        ADDR_o !== '0 || WDATA_o !== '0 || RDATA_o !== '0 || FAIL_o !== '0) begin
      errors++;
      $display("FAIL reset_outputs got gnt=%b ack=%b tr=%b rw=%b tout=%b addr=%h wd=%h rd=%h fail=%b exp all 0",
               GNT_o, ACK_o, TRANSFER_o, RW_o, TOUT_o, ADDR_o, WDATA_o, RDATA_o, FAIL_o);
    end
    PRESETn = 1'b1;
    exp_last = 3;
    tick();
  endtask

  task automatic test_round_robin();
    int w;
    int exp_order [5] = '{0, 1, 2, 3, 0};
    REQ_i = 4'b1111; RW_i = 4'b0101;
    for (int j = 0; j < 4; j++) begin
      ADDR_i[j*AW +: AW]  = 32'h100 + 32'(j);
      WDATA_i[j*DW +: DW] = 32'hC0DE_0000 + 32'(j);
    end
    for (int n = 0; n < 5; n++) begin
      run_txn(2, '0, $urandom, 1'b0, w);
      checks++; if (w !== exp_order[n]) begin errors++; $display("FAIL rr_order got %0d exp %0d", w, exp_order[n]); end
    end
    REQ_i = 4'b0;
  endtask

  task automatic test_single_write();
    int w;
    REQ_i = 4'b0001; RW_i = 4'b0001;
    ADDR_i[0 +: AW] = 32'h10; WDATA_i[0 +: DW] = 32'hA5A5_A5A5;
    run_txn(2, 2'b00, $urandom, 1'b1, w);
    checks++; if (ADDR_o !== 32'h10 || WDATA_o !== 32'hA5A5_A5A5) begin errors++; $display("FAIL single_write got %h %h exp 10 a5a5a5a5", ADDR_o, WDATA_o); end
  endtask

  task automatic test_read_capture();
    int w;
    REQ_i = 4'b0100; RW_i = 4'b0000;
    ADDR_i[2*AW +: AW] = 32'h2000_0040;
    run_txn(3, 2'b01, 32'hDEAD_BEEF, 1'b1, w);
    checks++; if (w !== 2 || RDATA_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read_capture got w=%0d rdata=%h exp 2 deadbeef", w, RDATA_o); end
  endtask

  task automatic test_timeout();
    int w;
    logic [3:0] oh;
    logic exp_t;
    REQ_i = 4'b1000; RW_i = 4'b1000;
    w = rr_pick(REQ_i, exp_last);
    oh = 4'b0001 << w;
    tick();
    checks++; if (TRANSFER_o !== 1'b1 || GNT_o !== oh) begin errors++; $display("FAIL tout_issue got tr=%b gnt=%b exp 1 %b", TRANSFER_o, GNT_o, oh); end
    for (int i = 1; i <= 7; i++) begin
      tick();
`ifdef APB_REQ_ARB_TOUT_EN
      exp_t = (i - 1) >= TC;
`else
      exp_t = 1'b0;
`endif
      checks++; if (TOUT_o !== exp_t) begin errors++; $display("FAIL tout_wait%0d got %b exp %b", i, TOUT_o, exp_t); end
    end
    DONE_i = 1'b1; FAIL_i = 2'b10; RDATA_i = 32'h1234_5678;
    tick();
    DONE_i = 1'b0; FAIL_i = '0;
    checks++; if (TOUT_o !== 1'b0 || FAIL_o !== 2'b10 || ACK_o !== oh) begin errors++; $display("FAIL tout_done got tout=%b fail=%b ack=%b exp 0 10 %b", TOUT_o, FAIL_o, ACK_o, oh); end
    REQ_i[w] = 1'b0;
    exp_last = w;
    tick();
  endtask

  task automatic test_reset_mid_wait();
    int w;
    REQ_i = 4'b0100; RW_i = 4'b0100;
    tick(); tick(); tick();
    #2 PRESETn = 1'b0;
    #1;
    checks++;
    if (GNT_o !== 4'b0 || ACK_o !== 4'b0 || TRANSFER_o !== 1'b0 || RW_o !== 1'b0 || TOUT_o !== 1'b0 ||
        ADDR_o !== '0 || WDATA_o !== '0 || RDATA_o !== '0 || FAIL_o !== '0) begin
      errors++;
      $display("FAIL async_reset got gnt=%b ack=%b tr=%b addr=%h rd=%h exp all 0", GNT_o, ACK_o, TRANSFER_o, ADDR_o, RDATA_o);
    end
    DONE_i = 1'b1;
    tick();
    DONE_i = 1'b0;
    REQ_i = 4'b0010;
    PRESETn = 1'b1;
    exp_last = 3;
    checks++; if (ACK_o !== 4'b0) begin errors++; $display("FAIL reset_no_ack got %b exp 0000", ACK_o); end
    run_txn(1, 2'b00, $urandom, 1'b1, w);
  endtask

  task automatic test_spurious_done();
    int w;
    REQ_i = 4'b0;
    DONE_i = 1'b1;
    tick(); tick();
    DONE_i = 1'b0;
    checks++; if (ACK_o !== 4'b0 || GNT_o !== 4'b0 || TRANSFER_o !== 1'b0) begin errors++; $display("FAIL spurious_done got ack=%b gnt=%b tr=%b exp 0", ACK_o, GNT_o, TRANSFER_o); end
    REQ_i = 4'b0001;
    run_txn(1, 2'b00, $urandom, 1'b1, w);
  endtask

  task automatic test_random();
    int w;
    for (int n = 0; n < 30; n++) begin
      for (int j = 0; j < 4; j++) begin
        if (!REQ_i[j] && $urandom_range(0, 1) == 1) begin
          REQ_i[j] = 1'b1;
          RW_i[j] = 1'($urandom);
          ADDR_i[j*AW +: AW] = $urandom;
          WDATA_i[j*DW +: DW] = $urandom;
        end
      end
      if (REQ_i == 4'b0) begin
        REQ_i[0] = 1'b1;
        ADDR_i[0 +: AW] = $urandom;
      end
      run_txn($urandom_range(1, 4), EW'($urandom), $urandom, 1'b1, w);
    end
    for (int n = 0; n < 4; n++)
      if (REQ_i != 4'b0) run_txn($urandom_range(1, 4), EW'($urandom), $urandom, 1'b1, w);
  endtask

  // Monitor: two consecutive launch pulses are never legal.
  logic prev_tr = 1'b0;
  always @(negedge PCLK) begin
    if (PRESETn === 1'b1) begin
      if (prev_tr && TRANSFER_o) begin
        checks++; errors++;
        $display("FAIL transfer_back_to_back got 1 exp 0");
      end
      prev_tr <= TRANSFER_o;
    end else begin
      prev_tr <= 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_round_robin();
    test_single_write();
    test_read_capture();
    test_timeout();
    test_reset_mid_wait();
    test_spurious_done();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
